// File: rtl/wind_lights.sv
// Wind-direction light sequencer: a prescaler gates pattern steps, and the wind code
// sampled on each step selects calm alternation, a one-hot walk in either direction, or blank.
module wind_lights #(
  parameter int N        = 3,
  parameter int TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   wind,
  input  logic         hold,
  output logic [N-1:0] lights,
  output logic         step,
  output logic         invalid
);

  // mode      | meaning
  // MODE_CALM | alternate even/odd masks
  // MODE_R2L  | one-hot walking toward bit N-1
  // MODE_L2R  | one-hot walking toward bit 0
  // MODE_INV  | lights blank, invalid flagged
  // MODE_NONE | post-reset, matches no wind code
  typedef enum logic [2:0] {
    MODE_CALM = 3'd0,
    MODE_R2L  = 3'd1,
    MODE_L2R  = 3'd2,
    MODE_INV  = 3'd3,
    MODE_NONE = 3'd4
  } mode_t;

  localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  function automatic logic [N-1:0] even_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = ~i[0];
    return m;
  endfunction

  localparam logic [N-1:0] EVEN  = even_mask();
  localparam logic [N-1:0] ODD   = ~EVEN;
  localparam logic [N-1:0] RIGHT = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] LEFT  = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] start_pattern(input mode_t m);
    case (m)
      MODE_CALM: return EVEN;
      MODE_R2L:  return RIGHT;
      MODE_L2R:  return LEFT;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] next_pattern(input mode_t m, input logic [N-1:0] cur);
    case (m)
      MODE_CALM: return (cur == EVEN) ? ODD : EVEN;
      MODE_R2L:  return {cur[N-2:0], cur[N-1]};
      MODE_L2R:  return {cur[0], cur[N-1:1]};
      default:   return '0;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  mode_t         mode_q, mode_d;
  logic [N-1:0]  lights_q, lights_d;
  logic          step_q, step_d;
  logic          invalid_q, invalid_d;
  logic          step_ev;
  mode_t         wind_mode;

  assign step_ev   = !hold && (cnt_q == CNT_MAX);
  assign wind_mode = mode_t'({1'b0, wind});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      mode_q    <= MODE_NONE;
      lights_q  <= '0;
      step_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      lights_q  <= lights_d;
      step_q    <= step_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    lights_d  = lights_q;
    invalid_d = invalid_q;
    step_d    = 1'b0;
    if (!hold) cnt_d = step_ev ? '0 : cnt_q + 1'b1;
    if (step_ev) begin
      step_d    = 1'b1;
      mode_d    = wind_mode;
      invalid_d = (wind_mode == MODE_INV);
      // A direction change restarts from the new mode's start pattern.
      if (wind_mode != mode_q) lights_d = start_pattern(wind_mode);
      else                     lights_d = next_pattern(mode_q, lights_q);
    end
  end

  assign lights  = lights_q;
  assign step    = step_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_wind_lights.sv
// Bench for wind_lights: three instances (N=3/TD=1, N=8/TD=4, N=5/TD=1) with
// queued expected patterns popped by per-instance monitors whenever step is high.
module tb_wind_lights;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst_a = 1'b1, hold_a = 1'b0;
  logic [1:0] wind_a = 2'b00;
  logic [2:0] lights_a;
  logic       step_a, inv_a;

  logic       rst_b = 1'b1, hold_b = 1'b0;
  logic [1:0] wind_b = 2'b00;
  logic [7:0] lights_b;
  logic       step_b, inv_b;

  logic       rst_c = 1'b1, hold_c = 1'b0;
  logic [1:0] wind_c = 2'b00;
  logic [4:0] lights_c;
  logic       step_c, inv_c;

  wind_lights #(.N(3), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(rst_a), .wind(wind_a), .hold(hold_a),
    .lights(lights_a), .step(step_a), .invalid(inv_a));
  wind_lights #(.N(8), .TICK_DIV(4)) dut_b (
    .clk(clk), .reset(rst_b), .wind(wind_b), .hold(hold_b),
    .lights(lights_b), .step(step_b), .invalid(inv_b));
  wind_lights #(.N(5), .TICK_DIV(1)) dut_c (
    .clk(clk), .reset(rst_c), .wind(wind_c), .hold(hold_c),
    .lights(lights_c), .step(step_c), .invalid(inv_c));

  // Expected {invalid, lights} per step, oldest first.
  logic [3:0] q_a[$];
  logic [8:0] q_b[$];
  logic [5:0] q_c[$];
  logic [3:0] e_a;
  logic [8:0] e_b;
  logic [5:0] e_c;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (step_a) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_step actual=%b expected=no_step", {inv_a, lights_a});
      end else begin
        e_a = q_a.pop_front();
        if ({inv_a, lights_a} !== e_a) begin
          failures++;
          $display("FAIL a_pattern actual=%b expected=%b t=%0t", {inv_a, lights_a}, e_a, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (step_b) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_step actual=%b expected=no_step", {inv_b, lights_b});
      end else begin
        e_b = q_b.pop_front();
        if ({inv_b, lights_b} !== e_b) begin
          failures++;
          $display("FAIL b_pattern actual=%b expected=%b t=%0t", {inv_b, lights_b}, e_b, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (step_c) begin
      checks++;
      if (q_c.size() == 0) begin
        failures++;
        $display("FAIL c_unexpected_step actual=%b expected=no_step", {inv_c, lights_c});
      end else begin
        e_c = q_c.pop_front();
        if ({inv_c, lights_c} !== e_c) begin
          failures++;
          $display("FAIL c_pattern actual=%b expected=%b t=%0t", {inv_c, lights_c}, e_c, $time);
        end
      end
    end
  end

  task automatic drive_a(input logic [1:0] w, input logic [3:0] e);
    wind_a = w;
    q_a.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive_c(input logic [1:0] w, input logic [5:0] e);
    wind_c = w;
    q_c.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("a_rst_lights", 16'(lights_a), 16'h0);
    chk("a_rst_step", 16'(step_a), 16'h0);
    chk("b_rst_lights", 16'(lights_b), 16'h0);
    wind_a = 2'b11;
    hold_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_rst_held_lights", 16'(lights_a), 16'h0);
    chk("a_rst_held_inv", 16'(inv_a), 16'h0);
    chk("a_rst_held_step", 16'(step_a), 16'h0);

    // N=3 TD=1: calm, right-to-left, left-to-right, invalid, back to calm
    rst_a = 1'b0;
    drive_a(2'b00, 4'b0101);
    drive_a(2'b00, 4'b0010);
    drive_a(2'b00, 4'b0101);
    drive_a(2'b00, 4'b0010);
    drive_a(2'b01, 4'b0001);
    drive_a(2'b01, 4'b0010);
    drive_a(2'b01, 4'b0100);
    drive_a(2'b01, 4'b0001);
    drive_a(2'b10, 4'b0100);
    drive_a(2'b10, 4'b0010);
    drive_a(2'b10, 4'b0001);
    drive_a(2'b10, 4'b0100);
    drive_a(2'b11, 4'b1000);
    drive_a(2'b11, 4'b1000);
    drive_a(2'b00, 4'b0101);
    hold_a = 1'b1;
    wind_a = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("a_hold_step", 16'(step_a), 16'h0);
      chk("a_hold_lights", 16'(lights_a), 16'h5);
    end
    hold_a = 1'b0;
    drive_a(2'b00, 4'b0010);
    #2 rst_a = 1'b1;
    #1 chk("a_async_rst_lights", 16'(lights_a), 16'h0);

    // N=8 TD=4: first step 4 edges after release, glitch on wind ignored, hold freezes
    @(negedge clk);
    wind_b = 2'b10;
    rst_b  = 1'b0;
    q_b.push_back({1'b0, 8'h80});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("b_first_step", 16'(step_b), 16'(i == 4));
      if (i == 3) chk("b_pre_lights", 16'(lights_b), 16'h0);
    end
    wind_b = 2'b01;
    q_b.push_back({1'b0, 8'h40});
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) wind_b = 2'b10;
      chk("b_second_step", 16'(step_b), 16'(i == 8));
    end
    repeat (2) @(negedge clk);
    hold_b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("b_hold_step", 16'(step_b), 16'h0);
      chk("b_hold_lights", 16'(lights_b), 16'h40);
    end
    hold_b = 1'b0;
    q_b.push_back({1'b0, 8'h20});
    @(negedge clk);
    chk("b_resume_wait", 16'(step_b), 16'h0);
    @(negedge clk);
    chk("b_resume_step", 16'(step_b), 16'h1);
    #2 rst_b = 1'b1;

    // N=5 TD=1: async reset mid-walk restarts from bit 0
    @(negedge clk);
    rst_c = 1'b0;
    drive_c(2'b01, 6'b000001);
    drive_c(2'b01, 6'b000010);
    drive_c(2'b01, 6'b000100);
    #2 rst_c = 1'b1;
    #1;
    chk("c_async_rst_lights", 16'(lights_c), 16'h0);
    chk("c_async_rst_step", 16'(step_c), 16'h0);
    @(negedge clk);
    rst_c = 1'b0;
    drive_c(2'b01, 6'b000001);
    drive_c(2'b01, 6'b000010);
    #2 rst_c = 1'b1;

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 16'(q_a.size()), 16'h0);
    chk("b_queue_drained", 16'(q_b.size()), 16'h0);
    chk("c_queue_drained", 16'(q_c.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wind_lights.md
WIND_LIGHTS -- requirements
Module: wind_lights

Interface
REQ-001 Parameter N, default 3, number of lights; legal range 3..16.
REQ-002 Parameter TICK_DIV, default 1, clk cycles per pattern step; legal range 1..2^24.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 wind  input  2  direction select: 00 calm, 01 right-to-left, 10 left-to-right, 11 invalid.
REQ-006 hold  input  1  high freezes prescaler and pattern.
REQ-007 lights  output  N  registered light pattern; bit 0 rightmost, bit N-1 leftmost.
REQ-008 step  output  1  registered one-cycle pulse, high in the cycle a new pattern appears on lights.
REQ-009 invalid  output  1  registered; high while the active mode is 11.

Function
REQ-010 Prescaler cnt SHALL count 0..TICK_DIV-1 and wrap to 0; it advances only when hold=0.
REQ-011 A step event SHALL occur on an edge where hold=0 and cnt=TICK_DIV-1; with TICK_DIV=1 every unheld edge is a step event.
REQ-012 hold=1 SHALL freeze cnt, mode, lights and invalid, and force step=0; releasing hold resumes counting from the frozen cnt.
REQ-013 wind SHALL be sampled only on step events; changes between step events have no effect.
REQ-014 Mode register: on each step event, mode <= wind.
REQ-015 If wind equals mode at the step event, the pattern SHALL advance one position in the current mode.
REQ-016 If wind differs from mode at the step event, the pattern SHALL load the start pattern of the new mode (no intermediate pattern).
REQ-017 Calm (00): alternates EVEN mask (bits 0,2,4,..) and ODD mask (bits 1,3,..); start = EVEN (N=3: 101, 010, 101, ...).
REQ-018 Right-to-left (01): one-hot; start = bit 0; advance = shift toward bit N-1; bit N-1 wraps to bit 0.
REQ-019 Left-to-right (10): one-hot; start = bit N-1; advance = shift toward bit 0; bit 0 wraps to bit N-1.
REQ-020 Invalid (11): lights = all zeros, invalid=1; entering or staying in 11 on a step event keeps lights zero.
REQ-021 Leaving 11 on a step event SHALL clear invalid and load the start pattern of the new mode.
REQ-022 step SHALL be 1 exactly in the cycle following each step event and 0 otherwise.
REQ-023 Output latency: lights, invalid and step SHALL update on the same edge as the step event (no combinational path from wind or hold to outputs).
REQ-024 Implementation SHALL use one-hot/shift logic generic in N; no per-N case tables.

Reset
REQ-025 On reset assertion, asynchronously: lights=0, step=0, invalid=0, cnt=0, mode=NONE (a value matching no wind code, forcing a start-pattern load on the first step event).
REQ-026 Reset asserted mid-pattern or mid-prescale SHALL discard all progress; after release the first step event occurs TICK_DIV unheld edges later and loads the start pattern of the sampled wind.
REQ-027 Outputs SHALL remain at reset values while reset is high regardless of wind or hold.

Verification
REQ-028 N=3, TICK_DIV=1, reset then wind=00 for 4 edges -> lights 101, 010, 101, 010; step=1 every cycle.
REQ-029 N=3, TICK_DIV=1, wind=01 for 4 edges after calm -> 001, 010, 100, 001; then wind=10 -> 100, 010, 001, 100 (start pattern on change, wrap correct).
REQ-030 N=8, TICK_DIV=4, wind=10 -> lights 1000_0000 appears 4 edges after reset release, then 0100_0000 4 edges later; step high for 1 of every 4 cycles; wind toggled to 01 for 1 cycle between step events -> ignored.
REQ-031 N=3, TICK_DIV=1, wind=11 -> lights=000, invalid=1; then wind=00 -> lights=101, invalid=0 on next edge.
REQ-032 N=8, TICK_DIV=4, hold=1 for 10 cycles mid-pattern -> lights, cnt frozen, step=0; on release next step occurs after remaining cnt cycles.
REQ-033 Reset asserted asynchronously between edges mid-walk (N=5, wind=01) -> lights=00000 immediately; after release first pattern = 00001.
